// File: rtl/alu_unit.sv
// alu_unit: integer execution unit behind the reservation station.
// Computes ALU results and branch/jump outcomes for one issued instruction
// per cycle and holds them in a 2-entry queue until the CDB grants broadcast.
module alu_unit #(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_en,
    input  logic [ROB_W-1:0] in_rob_pos,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7,
    input  logic [31:0]      in_val1,
    input  logic [31:0]      in_val2,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    output logic             in_full,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_rob_pos,
    output logic [31:0]      out_val,
    output logic             out_jump,
    output logic [31:0]      out_target,
    input  logic             out_gnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Queue entry layout: {rob tag, result, jump flag, next-PC}
    localparam int ENT_W = ROB_W + 65;

    logic [31:0]      op_b;
    logic [4:0]       shamt;
    logic [31:0]      alu_res;
    logic             br_taken;
    logic [31:0]      pc_plus4;
    logic [31:0]      res_val;
    logic             res_jump;
    logic [31:0]      res_target;

    logic [ENT_W-1:0] q [2];
    logic [1:0]       count;
    logic             head;
    logic             tail;
    logic             do_push;
    logic             do_pop;

    // Arithmetic/logic result for OP and OP-IMM, sub only for register form
    always_comb begin
        op_b    = (in_opcode == OPC_OP) ? in_val2 : in_imm;
        shamt   = op_b[4:0];
        alu_res = '0;
        case (in_funct3)
            3'b000: alu_res = (in_opcode == OPC_OP && in_funct7) ? (in_val1 - op_b)
                                                                 : (in_val1 + op_b);
            3'b001: alu_res = in_val1 << shamt;
            3'b010: alu_res = {31'b0, $signed(in_val1) < $signed(op_b)};
            3'b011: alu_res = {31'b0, in_val1 < op_b};
            3'b100: alu_res = in_val1 ^ op_b;
            3'b101: alu_res = in_funct7 ? $unsigned($signed(in_val1) >>> shamt)
                                        : (in_val1 >> shamt);
            3'b110: alu_res = in_val1 | op_b;
            3'b111: alu_res = in_val1 & op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition on the two register operands
    always_comb begin
        br_taken = 1'b0;
        case (in_funct3)
            3'b000: br_taken = (in_val1 == in_val2);
            3'b001: br_taken = (in_val1 != in_val2);
            3'b100: br_taken = ($signed(in_val1) <  $signed(in_val2));
            3'b101: br_taken = ($signed(in_val1) >= $signed(in_val2));
            3'b110: br_taken = (in_val1 <  in_val2);
            3'b111: br_taken = (in_val1 >= in_val2);
            default: br_taken = 1'b0;
        endcase
    end

    // Per-opcode result, redirect flag and next-PC for the entry being issued
    always_comb begin
        pc_plus4   = in_pc + 32'd4;
        res_val    = '0;
        res_jump   = 1'b0;
        res_target = pc_plus4;
        case (in_opcode)
            OPC_OP, OPC_OP_IMM: res_val = alu_res;
            OPC_LUI:            res_val = in_imm;
            OPC_AUIPC:          res_val = in_pc + in_imm;
            OPC_JAL: begin
                res_val    = pc_plus4;
                res_jump   = 1'b1;
                res_target = in_pc + in_imm;
            end
            OPC_JALR: begin
                res_val    = pc_plus4;
                res_jump   = 1'b1;
                res_target = (in_val1 + in_imm) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                res_jump   = br_taken;
                res_target = br_taken ? (in_pc + in_imm) : pc_plus4;
            end
            default: ;
        endcase
    end

    assign in_full   = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign do_push   = in_en && !in_full;
    assign do_pop    = out_valid && out_gnt;
    assign {out_rob_pos, out_val, out_jump, out_target} = q[head];

    // Output FIFO: reset clears storage so outputs read zero until the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            q[0]  <= '0;
            q[1]  <= '0;
        end else if (rollback) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (rdy) begin
            if (do_push) begin
                q[tail] <= {in_rob_pos, res_val, res_jump, res_target};
                tail    <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an
// in-bench queue model that computes results from RV32I semantics.
module tb_alu_unit;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] target;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_en, in_funct7, out_gnt;
    logic [3:0]  in_rob_pos;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_val1, in_val2, in_imm, in_pc;
    logic        in_full, out_valid, out_jump;
    logic [3:0]  out_rob_pos;
    logic [31:0] out_val, out_target;

    int   checks = 0;
    int   errors = 0;
    ent_t model_q[$];
    bit   started = 0;
    bit   pushed = 0;
    logic [3:0] tag = 4'd0;

    alu_unit #(.ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_en(in_en), .in_rob_pos(in_rob_pos), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_val1(in_val1), .in_val2(in_val2), .in_imm(in_imm), .in_pc(in_pc),
        .in_full(in_full), .out_valid(out_valid), .out_rob_pos(out_rob_pos),
        .out_val(out_val), .out_jump(out_jump), .out_target(out_target),
        .out_gnt(out_gnt)
    );

    always #5 clk = ~clk;

    // Reference semantics of one instruction, straight from the ISA rules
    function automatic ent_t refCompute(logic [3:0] rob, logic [6:0] op, logic [2:0] f3,
                                        logic f7, logic [31:0] a, logic [31:0] v2,
                                        logic [31:0] imm, logic [31:0] pc);
        ent_t e;
        logic [31:0] b;
        int sa, sb, sh;
        bit taken;
        e.rob = rob; e.val = 0; e.jump = 0; e.target = pc + 4;
        b = (op == OP) ? v2 : imm;
        sa = a; sb = (op == BRANCH) ? int'(v2) : int'(b);
        sh = int'(b % 32);
        if (op == OP || op == OPIMM) begin
            case (f3)
                0: e.val = (op == OP && f7) ? a - b : a + b;
                1: e.val = a << sh;
                2: e.val = (sa < sb) ? 1 : 0;
                3: e.val = (a < b) ? 1 : 0;
                4: e.val = a ^ b;
                5: e.val = f7 ? 32'(sa >>> sh) : a >> sh;
                6: e.val = a | b;
                7: e.val = a & b;
            endcase
        end else if (op == LUI) e.val = imm;
        else if (op == AUIPC) e.val = pc + imm;
        else if (op == JAL) begin
            e.val = pc + 4; e.jump = 1; e.target = pc + imm;
        end else if (op == JALR) begin
            e.val = pc + 4; e.jump = 1; e.target = (a + imm) & 32'hFFFFFFFE;
        end else if (op == BRANCH) begin
            case (f3)
                0: taken = (a == v2);
                1: taken = (a != v2);
                4: taken = (sa < sb);
                5: taken = (sa >= sb);
                6: taken = (a < v2);
                7: taken = (a >= v2);
                default: taken = 0;
            endcase
            e.jump = taken;
            e.target = taken ? pc + imm : pc + 4;
        end
        return e;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic en, logic [6:0] op, logic [2:0] f3, logic f7,
                                 logic [31:0] v1, logic [31:0] v2, logic [31:0] imm,
                                 logic [31:0] pc, logic [3:0] rob);
        in_en = en; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_val1 = v1; in_val2 = v2; in_imm = imm; in_pc = pc; in_rob_pos = rob;
    endtask

    // Model queue advances on every rising edge with the same priority rules
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete(); pushed = 0; started = 1;
        end else if (rollback) begin
            model_q.delete();
        end else if (rdy) begin
            bit pop_now, push_now;
            pop_now  = (model_q.size() > 0) && out_gnt;
            push_now = in_en && (model_q.size() < 2);
            if (pop_now) model_q.delete(0);
            if (push_now) begin
                model_q.push_back(refCompute(in_rob_pos, in_opcode, in_funct3, in_funct7,
                                             in_val1, in_val2, in_imm, in_pc));
                pushed = 1;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (started) begin
            checkOutput("cmp_valid", 32'(out_valid), 32'(model_q.size() != 0));
            checkOutput("cmp_full", 32'(in_full), 32'(model_q.size() == 2));
            if (model_q.size() != 0) begin
                checkOutput("cmp_rob", 32'(out_rob_pos), 32'(model_q[0].rob));
                checkOutput("cmp_val", out_val, model_q[0].val);
                checkOutput("cmp_jump", 32'(out_jump), 32'(model_q[0].jump));
                checkOutput("cmp_target", out_target, model_q[0].target);
            end else if (!pushed) begin
                checkOutput("cmp_rst_rob", 32'(out_rob_pos), 0);
                checkOutput("cmp_rst_val", out_val, 0);
                checkOutput("cmp_rst_jump", 32'(out_jump), 0);
                checkOutput("cmp_rst_target", out_target, 0);
            end
        end
    end

    // Issue one instruction into an empty queue and check the literal result next cycle
    task automatic issueAndCheck(string name, logic [6:0] op, logic [2:0] f3, logic f7,
                                 logic [31:0] v1, logic [31:0] v2, logic [31:0] imm,
                                 logic [31:0] ev, logic ej, logic [31:0] et);
        @(negedge clk);
        tag = tag + 1;
        out_gnt = 1;
        applyStimulus(1, op, f3, f7, v1, v2, imm, 32'h100, tag);
        @(negedge clk);
        in_en = 0;
        checkOutput({name, "_valid"}, 32'(out_valid), 1);
        checkOutput({name, "_val"}, out_val, ev);
        checkOutput({name, "_jump"}, 32'(out_jump), 32'(ej));
        checkOutput({name, "_target"}, out_target, et);
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0; out_gnt = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_full", 32'(in_full), 0);
        checkOutput("reset_val", out_val, 0);
        checkOutput("reset_target", out_target, 0);
        rst = 0;

        issueAndCheck("add_ovf", OP, 3'b000, 0, 32'h7FFFFFFF, 1, 0, 32'h80000000, 0, 32'h104);
        issueAndCheck("sub", OP, 3'b000, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 32'h104);
        issueAndCheck("addi_f7", OPIMM, 3'b000, 1, 5, 0, 3, 8, 0, 32'h104);
        issueAndCheck("srli", OPIMM, 3'b101, 0, 32'h80000000, 0, 4, 32'h08000000, 0, 32'h104);
        issueAndCheck("srai", OPIMM, 3'b101, 1, 32'h80000000, 0, 4, 32'hF8000000, 0, 32'h104);
        issueAndCheck("srl_0x24", OP, 3'b101, 0, 32'h80000000, 32'h24, 0, 32'h08000000, 0, 32'h104);
        issueAndCheck("slt", OP, 3'b010, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 32'h104);
        issueAndCheck("sltu", OP, 3'b011, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h104);
        issueAndCheck("bge", BRANCH, 3'b101, 0, -5, -5, 32'h20, 0, 1, 32'h120);
        issueAndCheck("bltu", BRANCH, 3'b110, 0, 5, 3, 32'h20, 0, 0, 32'h104);
        issueAndCheck("jalr", JALR, 3'b000, 0, 32'h201, 0, 0, 32'h104, 1, 32'h200);
        issueAndCheck("auipc", AUIPC, 3'b000, 0, 0, 0, 32'h20, 32'h120, 0, 32'h104);
        issueAndCheck("jal", JAL, 3'b000, 0, 0, 0, 32'h20, 32'h104, 1, 32'h120);
        issueAndCheck("lui", LUI, 3'b000, 0, 7, 7, 32'h12345000, 32'h12345000, 0, 32'h104);
        issueAndCheck("bad_op", 7'b0000000, 3'b000, 0, 7, 7, 32'h20, 0, 0, 32'h104);

        // Backpressure: three issues with no grant, third must be dropped
        @(negedge clk);
        out_gnt = 0;
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 32'h200, 4'hA);
        @(negedge clk);
        applyStimulus(1, OP, 0, 0, 2, 2, 0, 32'h204, 4'hB);
        @(negedge clk);
        checkOutput("bp_full", 32'(in_full), 1);
        applyStimulus(1, OP, 0, 0, 3, 3, 0, 32'h208, 4'hC);
        @(negedge clk);
        in_en = 0;
        checkOutput("bp_head_a", 32'(out_rob_pos), 32'hA);
        checkOutput("bp_full_hold", 32'(in_full), 1);
        out_gnt = 1;
        @(negedge clk);
        checkOutput("bp_head_b", 32'(out_rob_pos), 32'hB);
        checkOutput("bp_full_clear", 32'(in_full), 0);
        @(negedge clk);
        checkOutput("bp_empty", 32'(out_valid), 0);

        // Back-to-back issue with continuous grant
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, OPIMM, 0, 0, i, 0, 0, 32'h300, 4'(i));
            @(negedge clk);
            checkOutput("pp_tag", 32'(out_rob_pos), i);
            checkOutput("pp_count1", 32'(in_full), 0);
        end
        in_en = 0;
        @(negedge clk);
        checkOutput("pp_drain", 32'(out_valid), 0);

        // Fill, then rollback with concurrent issue and grant
        out_gnt = 0;
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h1);
        @(negedge clk);
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h2);
        @(negedge clk);
        rollback = 1; out_gnt = 1; in_rob_pos = 4'h3;
        @(negedge clk);
        rollback = 0; in_en = 0;
        checkOutput("rb_valid", 32'(out_valid), 0);
        checkOutput("rb_full", 32'(in_full), 0);

        // Fill, then reset with concurrent issue and grant
        out_gnt = 0;
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h4);
        @(negedge clk);
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h5);
        @(negedge clk);
        rst = 1; out_gnt = 1; in_rob_pos = 4'h6;
        @(negedge clk);
        rst = 0; in_en = 0;
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_full", 32'(in_full), 0);
        checkOutput("rst_val", out_val, 0);

        // rdy low freezes a full queue
        out_gnt = 0;
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h7);
        @(negedge clk);
        applyStimulus(1, OP, 0, 0, 1, 1, 0, 0, 4'h8);
        @(negedge clk);
        rdy = 0; out_gnt = 1; in_rob_pos = 4'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rdy_head", 32'(out_rob_pos), 32'h7);
            checkOutput("rdy_full", 32'(in_full), 1);
        end
        rdy = 1; in_en = 0;
        @(negedge clk);
        checkOutput("rdy_resume", 32'(out_rob_pos), 32'h8);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [31:0] v1, v2;
            @(negedge clk);
            case ($urandom_range(0, 8))
                0: op = OP;     1: op = OPIMM;  2: op = LUI;
                3: op = AUIPC;  4: op = JAL;    5: op = JALR;
                6: op = BRANCH; 7: op = BRANCH; default: op = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            if (op == BRANCH && (f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd0;
            v1 = $urandom;
            v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
            if ($urandom_range(0, 5) == 0) v1 = 32'h80000000;
            applyStimulus($urandom_range(0, 3) != 0, op, f3, 1'($urandom), v1, v2,
                          ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63)),
                          $urandom & 32'hFFFFFFFC, 4'($urandom));
            out_gnt  = ($urandom_range(0, 2) != 0);
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 49) == 0);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 0; rollback = 0; in_en = 0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Execution unit directly downstream of the reservation station. It accepts one issued integer instruction per cycle with both operands resolved and computes the result, plus branch/jump outcome and target. It buffers results in a 2-entry output queue until the common-data-bus arbiter grants broadcast. Flushed on `rollback`.

## Interface
- `ROB_W`, 4: width of ROB index tags.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rdy`  in  1  global enable; when low, all state holds and inputs are ignored.
- `rollback`  in  1  mispredict flush.
- `in_en`  in  1  issue strobe from the reservation station.
- `in_rob_pos`  in  ROB_W  destination ROB tag.
- `in_opcode`  in  7  RV32I opcode.
- `in_funct3`  in  3  funct3.
- `in_funct7`  in  1  instr bit 30 (sub/sra select).
- `in_val1`, `in_val2`  in  32  resolved rs1/rs2 values.
- `in_imm`  in  32  sign-extended immediate.
- `in_pc`  in  32  instruction PC.
- `in_full`  out  1  queue holds 2 entries; the issuer must not assert `in_en`.
- `out_valid`  out  1  head entry present.
- `out_rob_pos`  out  ROB_W  head tag.
- `out_val`  out  32  head result.
- `out_jump`  out  1  head redirects the PC (jal/jalr/taken branch).
- `out_target`  out  32  head next-PC.
- `out_gnt`  in  1  CDB grant; pops the head when `out_valid`.

## Operation
- Compute is combinational from the `in_*` inputs. On the edge where `in_en && !in_full`, the result is pushed into the queue tail.
- Opcode 0110011 (OP): operand b is `in_val2`.
- Opcode 0010011 (OP-IMM): operand b is `in_imm`. The sub select is ignored for OP-IMM; sra/srl selection uses `in_funct7`.
- funct3 decode:
  - 000: add/sub.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl/sra.
  - 110: or.
  - 111: and.
- Shift amount is b[4:0]. Arithmetic wraps mod 2^32. `out_jump`=0 and `out_target`=pc+4.
- LUI (0110111): val=imm. AUIPC (0010111): val=pc+imm. Neither jumps.
- JAL (1101111): val=pc+4, jump=1, target=pc+imm.
- JALR (1100111): val=pc+4, jump=1, target=(val1+imm)&~1.
- BRANCH (1100011): val=0. Condition by funct3:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Taken: jump=1, target=pc+imm. Not taken: jump=0, target=pc+4.
- Any other opcode: val=0, jump=0, target=pc+4. The entry is still pushed.
- The queue is a 2-entry FIFO with a 2-bit count, 1-bit head/tail pointers, and wrap-around.
- `out_*` reflect the head entry. `out_val`/`out_jump`/`out_target`/`out_rob_pos` are don't-care when `out_valid`=0, but hold reset values until the first push.

## Timing
- Reset state: count=0, `out_valid`=0, `in_full`=0, `out_rob_pos`=0, `out_val`=0, `out_jump`=0, `out_target`=0.
- Priority per edge: `rst` > `rollback` > `!rdy` (hold) > normal.
- Latency: issue at edge N gives `out_valid`=1 in cycle N+1 (if the queue was empty).
- Pop: on an edge with `out_valid && out_gnt`, the head advances. Entries emerge strictly in issue order.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes the head after the edge.
  - count=0: pop is impossible (`out_valid`=0); push only.
- `in_full` = (count==2), registered state only. With count=2 and `out_gnt`=1, `in_full` is still 1 that cycle; it deasserts the next cycle.
- `in_en` while `in_full`=1: ignored, nothing is pushed, and the queue is not corrupted.
- `rollback`: count→0 and `out_valid`=0 next cycle. An `in_en` and an `out_gnt` in the same cycle are both discarded. `in_full`=0 next cycle.
- `rdy`=0: no push and no pop. Outputs are held stable.
- `rst` mid-operation: identical to the reset state next cycle.

## Test plan
- Add/sub: OP add 0x7FFFFFFF+1 → `out_val`=0x80000000 in cycle N+1. OP sub (funct7=1) 0−1 → 0xFFFFFFFF. OP-IMM with funct7=1 and funct3=000 → add, not sub.
- Shifts: val1=0x80000000, b=4. srl → 0x08000000; sra → 0xF8000000. b=0x24 shifts by 4. slt(−1,1)=1; sltu(−1,1)=0.
- Control flow, pc=0x100, imm=0x20:
  - bge(−5,−5) → jump=1, target=0x120.
  - bltu(5,3) → jump=0, target=0x104.
  - jalr val1=0x201, imm=0 → val=0x104, target=0x200.
  - auipc → 0x120.
- Backpressure: hold `out_gnt`=0 and issue 3 in consecutive cycles. `in_full`=1 after the second. The third is dropped. Then grant for 2 cycles → the two tags emerge in order, and `in_full`=0 afterwards.
- Push+pop at count=1 with `out_gnt`=1 each cycle over 5 back-to-back issues → tags emerge 1:1 with 1-cycle latency and no loss.
- Flush: queue holds 2 entries, then `rollback` together with `in_en` and `out_gnt` → next cycle `out_valid`=0, `in_full`=0, and no entry is broadcast. Same check with `rst`; also `rdy`=0 freezes the queue for 3 cycles.
